// File: rtl/execute_stage.sv
// execute_stage: ALU, branch/jump resolution and the EX/MEM pipeline register.
// Define EXECUTE_MUL_EN to turn ALU op 1011 into an iterative shift-add multiply.
module execute_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExt_E,
  input  logic [XLEN-1:0] PC_Plus4E,
  input  logic [4:0]      RdE,
  input  logic            ValidE,
  input  logic [3:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic [2:0]      Funct3E,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            StallM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PC_Plus4M,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic            ValidM
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  if (MUL_CYCLES < 1) begin : g_mul_cycles_check
    $error("MUL_CYCLES must be at least 1");
  end

  logic [XLEN-1:0] w_src_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_mul_result;
  logic            w_mul_pending;
  logic            w_taken;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_pc_sum;

  assign w_src_b = ALUSrcE ? ImmExt_E : RD2E;
  assign w_shamt = w_src_b[4:0];

  // ALU
  always_comb begin
    w_alu_result = '0;
    case (ALUControlE)
      OP_ADD:  w_alu_result = RD1E + w_src_b;
      OP_SUB:  w_alu_result = RD1E - w_src_b;
      OP_AND:  w_alu_result = RD1E & w_src_b;
      OP_OR:   w_alu_result = RD1E | w_src_b;
      OP_XOR:  w_alu_result = RD1E ^ w_src_b;
      OP_SLT:  w_alu_result = XLEN'($signed(RD1E) < $signed(w_src_b));
      OP_SLTU: w_alu_result = XLEN'(RD1E < w_src_b);
      OP_SLL:  w_alu_result = RD1E << w_shamt;
      OP_SRL:  w_alu_result = RD1E >> w_shamt;
      OP_SRA:  w_alu_result = XLEN'($signed(RD1E) >>> w_shamt);
      OP_LUI:  w_alu_result = w_src_b;
      OP_MUL:  w_alu_result = w_mul_result;
      default: w_alu_result = '0;
    endcase
  end

  // Branch condition always compares the raw register operands
  always_comb begin
    w_taken = 1'b0;
    case (Funct3E)
      3'b000:  w_taken = (RD1E == RD2E);
      3'b001:  w_taken = (RD1E != RD2E);
      3'b100:  w_taken = ($signed(RD1E) <  $signed(RD2E));
      3'b101:  w_taken = ($signed(RD1E) >= $signed(RD2E));
      3'b110:  w_taken = (RD1E <  RD2E);
      3'b111:  w_taken = (RD1E >= RD2E);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_jalr_sum = RD1E + ImmExt_E;
  assign w_pc_sum   = PCE + ImmExt_E;
  assign PCTargetE  = JalrE ? (w_jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : w_pc_sum;
  assign PCSrcE     = ValidE & (JumpE | (BranchE & w_taken));
  assign StallE     = StallM | w_mul_pending;

`ifdef EXECUTE_MUL_EN
  localparam int unsigned CNTW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mul_state_e;

  mul_state_e      r_state;
  mul_state_e      w_state_next;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_prod;
  logic [CNTW-1:0] r_count;
  logic            w_mul_start;
  logic            w_last_step;

  assign w_mul_start   = (r_state == ST_IDLE) && ValidE && (ALUControlE == OP_MUL) && !StallM;
  assign w_last_step   = (r_count == CNTW'(MUL_CYCLES - 1));
  assign w_mul_pending = w_mul_start || (r_state == ST_BUSY);
  assign w_mul_result  = (r_state == ST_DONE) ? r_prod : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // DONE waits for the EX/MEM register to accept the product
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_next = ST_BUSY;
      ST_BUSY: if (w_last_step) w_state_next = ST_DONE;
      ST_DONE: if (!StallM)     w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_count  <= '0;
    end else if (w_mul_start) begin
      r_mcand  <= RD1E;
      r_mplier <= w_src_b;
      r_prod   <= '0;
      r_count  <= '0;
    end else if (r_state == ST_BUSY) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CNTW'(1);
    end
  end
`else
  assign w_mul_pending = 1'b0;
  assign w_mul_result  = '0;
`endif

  // EX/MEM register: hold on StallM, bubble while a multiply is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PC_Plus4M  <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ValidM     <= 1'b0;
    end else if (!StallM) begin
      if (w_mul_pending) begin
        ValidM    <= 1'b0;
        RegWriteM <= 1'b0;
        MemWriteM <= 1'b0;
      end else begin
        ALUResultM <= w_alu_result;
        WriteDataM <= RD2E;
        PC_Plus4M  <= PC_Plus4E;
        RdM        <= RdE;
        RegWriteM  <= RegWriteE & ValidE;
        MemWriteM  <= MemWriteE & ValidE;
        ResultSrcM <= ResultSrcE;
        ValidM     <= ValidE;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed stimulus against an arithmetic reference model of execute_stage.
// Follows EXECUTE_MUL_EN so the same bench covers both builds.
module tb_execute_stage;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MUL_CYCLES = 32;

  logic            clk;
  logic            reset;
  logic [31:0]     RD1E, RD2E, PCE, ImmExt_E, PC_Plus4E;
  logic [4:0]      RdE;
  logic            ValidE;
  logic [3:0]      ALUControlE;
  logic            ALUSrcE;
  logic [2:0]      Funct3E;
  logic            BranchE, JumpE, JalrE, RegWriteE, MemWriteE;
  logic [1:0]      ResultSrcE;
  logic            StallM;
  logic            PCSrcE;
  logic [31:0]     PCTargetE;
  logic            StallE;
  logic [31:0]     ALUResultM, WriteDataM, PC_Plus4M;
  logic [4:0]      RdM;
  logic            RegWriteM, MemWriteM;
  logic [1:0]      ResultSrcM;
  logic            ValidM;

  execute_stage #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExt_E(ImmExt_E), .PC_Plus4E(PC_Plus4E),
    .RdE(RdE), .ValidE(ValidE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .Funct3E(Funct3E), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .StallM(StallM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PC_Plus4M(PC_Plus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .ValidM(ValidM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] pc_q = 32'h0000_0100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] f_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9: begin
        t = {{32{a[31]}}, a} >> b[4:0];
        return t[31:0];
      end
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit f_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] fa, fb;
    fa = a ^ 32'h8000_0000;
    fb = b ^ 32'h8000_0000;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return fa < fb;
      3'd5: return fa >= fb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic [31:0] e_alu, e_wd, e_pc4;
  logic [4:0]  e_rd;
  logic        e_v, e_rw, e_mw;
  logic [1:0]  e_rs;
  int          m_left;
  bit          m_done;

  // Multiply occupancy: remaining stall cycles after the start cycle, then a product-ready flag
  function automatic bit f_pending();
`ifdef EXECUTE_MUL_EN
    return (m_left > 0) || (!m_done && ValidE && ALUControlE == 4'd11 && !StallM);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] f_result();
    logic [31:0] b;
    b = ALUSrcE ? ImmExt_E : RD2E;
    if (ALUControlE == 4'd11) begin
`ifdef EXECUTE_MUL_EN
      if (m_done) return RD1E * b;
`endif
      return 32'd0;
    end
    return f_alu(ALUControlE, RD1E, b);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_alu <= '0; e_wd <= '0; e_pc4 <= '0; e_rd <= '0;
      e_v <= 1'b0; e_rw <= 1'b0; e_mw <= 1'b0; e_rs <= '0;
      m_left <= 0; m_done <= 1'b0;
    end else begin
      if (!StallM) begin
        if (f_pending()) begin
          e_v <= 1'b0; e_rw <= 1'b0; e_mw <= 1'b0;
        end else begin
          e_alu <= f_result();
          e_wd  <= RD2E;
          e_pc4 <= PC_Plus4E;
          e_rd  <= RdE;
          e_v   <= ValidE;
          e_rw  <= RegWriteE & ValidE;
          e_mw  <= MemWriteE & ValidE;
          e_rs  <= ResultSrcE;
          m_done <= 1'b0;
        end
      end
`ifdef EXECUTE_MUL_EN
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_done <= 1'b1;
      end else if (!m_done && ValidE && ALUControlE == 4'd11 && !StallM) begin
        m_left <= int'(MUL_CYCLES);
      end
`endif
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("PCSrcE", 32'(PCSrcE), 32'(ValidE & (JumpE | (BranchE & f_taken(Funct3E, RD1E, RD2E)))));
      check("PCTargetE", PCTargetE, JalrE ? ((RD1E + ImmExt_E) & ~32'd1) : (PCE + ImmExt_E));
      check("StallE", 32'(StallE), 32'(StallM | f_pending()));
      check("ALUResultM", ALUResultM, e_alu);
      check("WriteDataM", WriteDataM, e_wd);
      check("PC_Plus4M", PC_Plus4M, e_pc4);
      check("RdM", 32'(RdM), 32'(e_rd));
      check("ValidM", 32'(ValidM), 32'(e_v));
      check("RegWriteM", 32'(RegWriteM), 32'(e_rw));
      check("MemWriteM", 32'(MemWriteM), 32'(e_mw));
      check("ResultSrcM", 32'(ResultSrcM), 32'(e_rs));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd,
                         input logic v, input logic rw, input logic mw);
    ALUControlE = op; ALUSrcE = src; RD1E = a; RD2E = b; ImmExt_E = imm; RdE = rd;
    ValidE = v; RegWriteE = rw; MemWriteE = mw;
    BranchE = 1'b0; JumpE = 1'b0; JalrE = 1'b0; Funct3E = 3'd0; ResultSrcE = 2'd0;
    PCE = pc_q; PC_Plus4E = pc_q + 32'd4;
    pc_q = pc_q + 32'd4;
  endtask

  logic [31:0] va [3];
  logic [31:0] vb [3];
  int          n;

  initial begin
    va[0] = 32'h8000_0010; vb[0] = 32'h0000_0004;
    va[1] = 32'h0000_0003; vb[1] = 32'hFFFF_FFFE;
    va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_003F;
    reset = 1'b0; StallM = 1'b0;
    set_alu(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset ValidM", 32'(ValidM), 32'd0);
    check("reset ALUResultM", ALUResultM, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // add with immediate
    set_alu(4'd0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFD, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    check("add ALUResultM", ALUResultM, 32'd2);
    check("add RdM", 32'(RdM), 32'd7);
    check("add RegWriteM", 32'(RegWriteM), 32'd1);
    check("add ValidM", 32'(ValidM), 32'd1);

    // beq taken / not taken
    set_alu(4'd0, 1'b0, 32'd9, 32'd9, 32'h20, 5'd0, 1'b1, 1'b0, 1'b0);
    BranchE = 1'b1; PCE = 32'h100;
    #1;
    check("beq PCSrcE", 32'(PCSrcE), 32'd1);
    check("beq PCTargetE", PCTargetE, 32'h120);
    RD2E = 32'd8;
    #1;
    check("beq nt PCSrcE", 32'(PCSrcE), 32'd0);
    tick();

    // jalr clears bit 0
    set_alu(4'd0, 1'b1, 32'h203, 32'd0, 32'h4, 5'd1, 1'b1, 1'b1, 1'b0);
    JumpE = 1'b1; JalrE = 1'b1;
    #1;
    check("jalr PCTargetE", PCTargetE, 32'h206);
    check("jalr PCSrcE", 32'(PCSrcE), 32'd1);
    tick();

    // sweep of all non-multiply ALU ops, register and immediate operand
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 3; k++) begin
        if (op != 11) begin
          set_alu(4'(op), k[0], va[k], vb[k], vb[(k + 1) % 3], 5'(op + k), 1'b1, 1'b1, 1'b0);
          tick();
        end
      end
    end
    set_alu(4'd9, 1'b0, 32'h8000_0010, 32'd4, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    check("sra", ALUResultM, 32'hF800_0001);
    set_alu(4'd5, 1'b0, 32'd3, 32'hFFFF_FFFE, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    check("slt", ALUResultM, 32'd0);
    set_alu(4'd6, 1'b0, 32'd3, 32'hFFFF_FFFE, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    check("sltu", ALUResultM, 32'd1);
    set_alu(4'd7, 1'b1, 32'd3, 32'd0, 32'h21, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    check("sll shamt", ALUResultM, 32'd6);
    set_alu(4'd1, 1'b0, 32'd5, 32'd7, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    check("sub", ALUResultM, 32'hFFFF_FFFE);

    // every branch condition on a signed/unsigned-split operand pair
    for (int f = 0; f < 8; f++) begin
      set_alu(4'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 32'h40, 5'd0, 1'b1, 1'b0, 1'b0);
      BranchE = 1'b1; Funct3E = 3'(f);
      #1;
      if (f == 6) check("bltu PCSrcE", 32'(PCSrcE), 32'd1);
      if (f == 4) check("blt PCSrcE", 32'(PCSrcE), 32'd0);
      tick();
    end

    // store with writeback-select passthrough
    set_alu(4'd0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 32'h8, 5'd0, 1'b1, 1'b0, 1'b1);
    ResultSrcE = 2'd2;
    tick();
    check("st MemWriteM", 32'(MemWriteM), 32'd1);
    check("st WriteDataM", WriteDataM, 32'hDEAD_BEEF);
    check("st ResultSrcM", 32'(ResultSrcM), 32'd2);

    // hold under StallM
    set_alu(4'd10, 1'b1, 32'd0, 32'd0, 32'hAA, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    check("hold ALUResultM pre", ALUResultM, 32'hAA);
    set_alu(4'd10, 1'b1, 32'd0, 32'd0, 32'h55, 5'd9, 1'b1, 1'b1, 1'b0);
    StallM = 1'b1;
    #1;
    check("hold StallE", 32'(StallE), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold ALUResultM", ALUResultM, 32'hAA);
      check("hold RdM", 32'(RdM), 32'd3);
    end
    StallM = 1'b0;
    tick();
    check("release ALUResultM", ALUResultM, 32'h55);
    check("release RdM", 32'(RdM), 32'd9);

    // invalid slot never writes
    set_alu(4'd0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd4, 1'b0, 1'b1, 1'b1);
    tick();
    check("inv RegWriteM", 32'(RegWriteM), 32'd0);
    check("inv MemWriteM", 32'(MemWriteM), 32'd0);
    check("inv ValidM", 32'(ValidM), 32'd0);

`ifdef EXECUTE_MUL_EN
    // iterative multiply, with StallM held briefly while the product waits
    set_alu(4'd11, 1'b0, 32'd7, 32'd6, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    n = 0;
    while (StallE && n < 100) begin
      tick();
      n++;
    end
    check("mul stall cycles", 32'(n), 32'd33);
    check("mul bubble ValidM", 32'(ValidM), 32'd0);
    StallM = 1'b1;
    repeat (2) tick();
    check("mul done held ValidM", 32'(ValidM), 32'd0);
    StallM = 1'b0;
    tick();
    check("mul ALUResultM", ALUResultM, 32'd42);
    check("mul ValidM", 32'(ValidM), 32'd1);
    set_alu(4'd0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();

    // reset in the middle of BUSY
    set_alu(4'd11, 1'b0, 32'd7, 32'd6, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    repeat (10) tick();
    reset = 1'b1; ValidE = 1'b0;
    #1;
    check("mulrst StallE", 32'(StallE), 32'd0);
    check("mulrst ValidM", 32'(ValidM), 32'd0);
    check("mulrst ALUResultM", ALUResultM, 32'd0);
    check("mulrst RdM", 32'(RdM), 32'd0);
    StallM = 1'b1;
    #1;
    check("mulrst StallE=StallM", 32'(StallE), 32'd1);
    StallM = 1'b0;
    tick();
    reset = 1'b0;
    set_alu(4'd0, 1'b0, 32'd20, 32'd22, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    #1;
    check("post-rst StallE", 32'(StallE), 32'd0);
    tick();
    check("post-rst ALUResultM", ALUResultM, 32'd42);
`else
    // without the multiplier op 1011 is a single-cycle zero
    set_alu(4'd11, 1'b0, 32'd7, 32'd6, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    check("mul-off StallE", 32'(StallE), 32'd0);
    tick();
    check("mul-off ALUResultM", ALUResultM, 32'd0);
    check("mul-off ValidM", 32'(ValidM), 32'd1);
`endif

    set_alu(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs (RD1E, RD2E, PCE, ImmExt_E, PC_Plus4E, RdE) plus decoded control.
- Performs the ALU operation, resolves branches and jumps, and computes the fetch redirect target.
- Registers results into the EX/MEM pipeline register for the memory stage.
- Adds a valid bit, a downstream hold input (StallM) and an upstream stall output (StallE) so multi-cycle operations can be inserted.

Parameters:
XLEN, 32, datapath width; only 32 is required to work.
MUL_CYCLES, 32, iteration count of the optional shift-add multiplier; must be ≥1.

Ports:
clk  input  1  clock, all flops on rising edge
reset  input  1  asynchronous, active-high; clears all state
RD1E  input  XLEN  rs1 operand
RD2E  input  XLEN  rs2 operand / store data
PCE  input  XLEN  PC of instruction in E
ImmExt_E  input  XLEN  sign-extended immediate
PC_Plus4E  input  XLEN  PC+4 of instruction in E
RdE  input  5  destination register
ValidE  input  1  E slot holds a real instruction
ALUControlE  input  4  ALU op select (encoding below)
ALUSrcE  input  1  0: SrcB=RD2E, 1: SrcB=ImmExt_E
Funct3E  input  3  branch condition select
BranchE  input  1  conditional branch
JumpE  input  1  jal/jalr
JalrE  input  1  target base is RD1E instead of PCE
RegWriteE  input  1  writes Rd
MemWriteE  input  1  store
ResultSrcE  input  2  writeback select, passed through
StallM  input  1  memory stage cannot accept; hold EX/MEM
PCSrcE  output  1  redirect fetch to PCTargetE
PCTargetE  output  XLEN  branch/jump target
StallE  output  1  E cannot advance; upstream must hold
ALUResultM  output  XLEN  registered ALU result
WriteDataM  output  XLEN  registered RD2E
PC_Plus4M  output  XLEN  registered PC_Plus4E
RdM  output  5  registered RdE
RegWriteM, MemWriteM  output  1 each  registered, gated by valid
ResultSrcM  output  2  registered ResultSrcE
ValidM  output  1  EX/MEM slot valid

Behaviour:
- ALUControlE encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt (signed), 0110 sltu, 0111 sll, 1000 srl, 1001 sra (shift amount = SrcB[4:0])
  - 1010 pass SrcB (lui), 1011 mul (optional), 11xx result 0
- Branch condition, combinational on RD1E vs RD2E, selected by Funct3E:
  - 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 never taken.
- PCTargetE = JalrE ? ((RD1E+ImmExt_E) & ~1) : (PCE+ImmExt_E); adds wrap modulo 2^XLEN.
- PCSrcE = ValidE & (JumpE | (BranchE & taken)); combinational; stays asserted while the instruction is held in E.
- StallE = StallM | mul_pending. mul_pending is 0 when the feature is compiled out.
- EX/MEM update on rising edge:
  - StallM=1: every EX/MEM flop holds.
  - StallM=0, mul_pending=1: insert bubble. ValidM, RegWriteM, MemWriteM ← 0; other fields don't-care but must be deterministic (hold).
  - Otherwise: all fields capture E values. ValidM←ValidE, RegWriteM←RegWriteE&ValidE, MemWriteM←MemWriteE&ValidE.
- Latency: one cycle E→M for every single-cycle op.
- Reset, asynchronous: all M outputs ← 0, multiplier FSM ← IDLE, counter ← 0. PCSrcE/PCTargetE follow inputs combinationally.

Optional Feature:
- Macro: EXECUTE_MUL_EN.
- Defined: op 1011 is an iterative shift-add multiply producing the low XLEN bits of RD1E*SrcB.
  - FSM states IDLE → BUSY → DONE → IDLE.
  - IDLE→BUSY when ValidE & op==1011 & !StallM: load operands, count←0.
  - BUSY: one shift-add step per cycle; after MUL_CYCLES steps → DONE.
  - mul_pending=1 from the IDLE-detect cycle through the last BUSY cycle, i.e. StallE high for MUL_CYCLES+1 cycles.
  - DONE: mul_pending=0; EX/MEM captures the product (subject to StallM); then → IDLE.
  - If StallM rises during DONE, stay in DONE until captured.
  - Reset in any state → IDLE with no writeback.
- Undefined: op 1011 produces 0, single cycle; no FSM; StallE = StallM.

Test Plan:
- ALUControlE=0000, ALUSrcE=1, RD1E=5, ImmExt_E=-3, RegWriteE=1, ValidE=1, RdE=7 → next cycle ALUResultM=2, RdM=7, RegWriteM=1, ValidM=1.
- BranchE=1, Funct3E=000, RD1E=RD2E=9, PCE=0x100, ImmExt_E=0x20 → same cycle PCSrcE=1, PCTargetE=0x120. With RD2E=8 → PCSrcE=0.
- JumpE=1, JalrE=1, RD1E=0x203, ImmExt_E=0x4 → PCTargetE=0x206, PCSrcE=1.
- Stall hold: StallM=1 for 3 cycles after ALUResultM=0xAA is captured → all M outputs stay at 0xAA/etc.; StallE=1. StallM=0 → next E instruction captured.
- ValidE=0 with RegWriteE=1, MemWriteE=1 → RegWriteM=0, MemWriteM=0, ValidM=0.
- EXECUTE_MUL_EN: op 1011, RD1E=7, RD2E=6 → StallE=1 for 33 cycles, bubble (ValidM=0) each; then ALUResultM=42, ValidM=1. Repeat with reset asserted mid-BUSY → all M outputs 0, FSM IDLE, StallE=StallM immediately.
